fsm_cmd_issue: RTL

//   Upstream command issuer for the read/write sequencing FSM: queues read/write requests

---
 rtl/fsm_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/fsm_cmd_issue.sv | 99 +++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared encodings for the read/write sequencing FSM and its command issuer.
// Select codes, request opcodes, issuer state encodings and an op-to-sel helper.
package fsm_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_RD   = 2'b01;
    localparam logic [1:0] SEL_WR   = 2'b10;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_CHAIN = 3'b010,
        S_GAP   = 3'b100
    } state_t;

    function automatic logic [1:0] op2sel(input logic op);
        return (op == OP_WR) ? SEL_WR : SEL_RD;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// 1-bit-wide command FIFO with head and head+1 peek and a 0..2 pop count.
// Ports: clk, rstn, flush, push/push_op, pop_cnt in; head, next, level out.
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   push_op,
    input  logic [1:0]             pop_cnt,
    output logic                   head,
    output logic                   next,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr1;

    assign rptr1 = rptr + AW'(1);
    assign head  = mem[rptr];
    assign next  = mem[rptr1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_op;
        end
    end

    // Full/empty come from level; pointers simply wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            rptr  <= rptr + AW'(pop_cnt);
            level <= level + LW'(push) - LW'(pop_cnt);
        end
    end

endmodule

// File: rtl/fsm_cmd_issue.sv
// Queues read/write requests and drives the FSM sel input with paced pulses.
// Ports: clk, rstn, cmd_valid/cmd_op/cmd_ready, flush in; sel, level, busy out.
module fsm_cmd_issue #(
    parameter int DEPTH    = 4,
    parameter int GAP      = 2,
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    input  logic                   cmd_op,
    output logic                   cmd_ready,
    input  logic                   flush,
    output logic [1:0]             sel,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    import fsm_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP + 1);

    state_t        state;
    logic [GW-1:0] gap;
    logic          head;
    logic          next;
    logic          push;
    logic          issue;
    logic          chain;
    logic [1:0]    pop_cnt;

    assign cmd_ready = (level != LW'(DEPTH)) & ~flush;
    assign push      = cmd_valid & cmd_ready;
    assign busy      = (state != S_IDLE) | (level != '0);

    assign issue = (state == S_IDLE) & (level != '0) & ~flush;

    // Read with a queued write behind it goes out as back-to-back pulses.
    assign chain = CHAIN_EN & issue
                 & (head == OP_RD)
                 & (level >= LW'(2))
                 & (next == OP_WR);

    assign pop_cnt = chain ? 2'd2 : (issue ? 2'd1 : 2'd0);

    cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (flush),
        .push   (push),
        .push_op(cmd_op),
        .pop_cnt(pop_cnt),
        .head   (head),
        .next   (next),
        .level  (level)
    );

    // Gap counter keeps the FSM quiet until it has returned to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            sel   <= SEL_NONE;
            gap   <= '0;
        end else begin
            unique case (1'b1)
                state[0]: begin
                    if (issue) begin
                        sel   <= op2sel(head);
                        gap   <= GW'(GAP);
                        state <= chain ? S_CHAIN : S_GAP;
                    end else begin
                        sel <= SEL_NONE;
                    end
                end
                state[1]: begin
                    sel   <= SEL_WR;
                    gap   <= gap - GW'(1);
                    state <= S_GAP;
                end
                state[2]: begin
                    sel <= SEL_NONE;
                    gap <= gap - GW'(1);
                    if (gap == GW'(1)) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    sel   <= SEL_NONE;
                    gap   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
